// File: rtl/cache_mem_rd_arbiter_pkg.sv
// Shared encodings for the I/D-cache line-refill read arbiter.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin tie breaking.
package cache_mem_rd_arbiter_pkg;

    // One-hot FSM state encodings
    localparam int unsigned STATE_W = 3;
    localparam logic [2:0]  ST_IDLE = 3'b001;
    localparam logic [2:0]  ST_REQ  = 3'b010;
    localparam logic [2:0]  ST_RESP = 3'b100;

    // Burst owner encoding
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Default beats per line refill and line offset width
    localparam int unsigned DEF_BURST_LEN = 8;
    localparam int unsigned LINE_OFF_W    = 5;
    localparam int unsigned BEAT_CNT_W    = 3;

    // The cache that is not the given one
    function automatic logic other_owner(input logic own);
        return ~own;
    endfunction

endpackage

// File: rtl/cache_mem_rd_arbiter_arb_grant.sv
// Two-way grant logic for the read arbiter.
// ARB_ROUND_ROBIN_EN defined: ties go to the cache not granted last.
// ARB_ROUND_ROBIN_EN undefined: ties always go to the D-cache.
module cache_mem_rd_arbiter_arb_grant
    import cache_mem_rd_arbiter_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic ic_req,
    input  logic dc_req,
    input  logic grant_en,
    output logic grant_valid_c,
    output logic grant_owner_c
);

    // A grant is issued whenever arbitration is open and anyone asks
    assign grant_valid_c = grant_en && (ic_req || dc_req);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q;

    // Remember who won the most recent grant; D wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= OWN_I;
        end else if (grant_valid_c) begin
            last_grant_q <= grant_owner_c;
        end
    end

    // Tie goes to the cache that lost last time; a lone requester wins
    always_comb begin
        grant_owner_c = OWN_I;
        if (ic_req && dc_req) begin
            grant_owner_c = other_owner(last_grant_q);
        end else if (dc_req) begin
            grant_owner_c = OWN_D;
        end
    end
`else
    // Fixed priority: D-cache wins any tie
    always_comb begin
        grant_owner_c = OWN_I;
        if (dc_req) begin
            grant_owner_c = OWN_D;
        end
    end
`endif

endmodule

// File: rtl/cache_mem_rd_arbiter.sv
// Arbitrates I-cache and D-cache line refill reads onto one memory read
// channel. The granted cache owns the channel for its whole burst.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin tie breaking instead of
// fixed D-cache priority.
module cache_mem_rd_arbiter
    import cache_mem_rd_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = DEF_BURST_LEN
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ic_rd_req_valid,
    input  logic [ADDR_WIDTH-1:0] ic_rd_req_addr,
    output logic                  ic_rd_req_ready,
    output logic                  ic_rd_rsp_valid,
    output logic [DATA_WIDTH-1:0] ic_rd_rsp_data,
    output logic                  ic_rd_rsp_last,
    input  logic                  ic_rd_rsp_ready,

    input  logic                  dc_rd_req_valid,
    input  logic [ADDR_WIDTH-1:0] dc_rd_req_addr,
    output logic                  dc_rd_req_ready,
    output logic                  dc_rd_rsp_valid,
    output logic [DATA_WIDTH-1:0] dc_rd_rsp_data,
    output logic                  dc_rd_rsp_last,
    input  logic                  dc_rd_rsp_ready,

    output logic                  to_mem_rd_req_valid,
    output logic [ADDR_WIDTH-1:0] to_mem_rd_req_addr,
    input  logic                  from_mem_rd_req_ready,
    input  logic                  from_mem_rd_rsp_valid,
    input  logic [DATA_WIDTH-1:0] from_mem_rd_rsp_data,
    input  logic                  from_mem_rd_rsp_last,
    output logic                  to_mem_rd_rsp_ready,

    output logic                  busy,
    output logic                  burst_err
);

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~ADDR_WIDTH'((1 << LINE_OFF_W) - 1);
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BURST_LEN - 1);

    logic [STATE_W-1:0]    state_q, state_d;
    logic                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic                  burst_err_q, burst_err_d;

    logic                  in_idle, in_req, in_resp;
    logic                  grant_valid_c, grant_owner_c;
    logic                  beat_hs;

    assign in_idle = (state_q == ST_IDLE);
    assign in_req  = (state_q == ST_REQ);
    assign in_resp = (state_q == ST_RESP);

    // Grant selection between the two caches
    cache_mem_rd_arbiter_arb_grant u_arb_grant (
`ifdef ARB_ROUND_ROBIN_EN
        .clk           (clk),
        .rst           (rst),
`endif
        .ic_req        (ic_rd_req_valid),
        .dc_req        (dc_rd_req_valid),
        .grant_en      (in_idle),
        .grant_valid_c (grant_valid_c),
        .grant_owner_c (grant_owner_c)
    );

    // A beat moves when memory offers it and the owner accepts it
    assign beat_hs = in_resp && from_mem_rd_rsp_valid && to_mem_rd_rsp_ready;

    // State, owner, line address, beat count and error registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_I;
            addr_q      <= '0;
            beat_cnt_q  <= '0;
            burst_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            beat_cnt_q  <= beat_cnt_d;
            burst_err_q <= burst_err_d;
        end
    end

    // Next-state logic: grant in IDLE, request in REQ, stream beats in RESP
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        beat_cnt_d  = beat_cnt_q;
        burst_err_d = burst_err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_valid_c) begin
                    owner_d    = grant_owner_c;
                    addr_d     = ((grant_owner_c == OWN_D) ? dc_rd_req_addr
                                                           : ic_rd_req_addr) & LINE_MASK;
                    beat_cnt_d = '0;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (from_mem_rd_req_ready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (beat_hs) begin
                    beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
                    if (from_mem_rd_rsp_last) begin
                        state_d = ST_IDLE;
                        if (beat_cnt_q != LAST_BEAT) begin
                            burst_err_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Channel steering: only the owner sees handshakes and beats
    always_comb begin
        to_mem_rd_req_valid = 1'b0;
        to_mem_rd_req_addr  = '0;
        to_mem_rd_rsp_ready = 1'b0;
        ic_rd_req_ready     = 1'b0;
        dc_rd_req_ready     = 1'b0;
        ic_rd_rsp_valid     = 1'b0;
        ic_rd_rsp_data      = '0;
        ic_rd_rsp_last      = 1'b0;
        dc_rd_rsp_valid     = 1'b0;
        dc_rd_rsp_data      = '0;
        dc_rd_rsp_last      = 1'b0;
        if (in_req) begin
            to_mem_rd_req_valid = 1'b1;
            to_mem_rd_req_addr  = addr_q;
            if (owner_q == OWN_D) begin
                dc_rd_req_ready = from_mem_rd_req_ready;
            end else begin
                ic_rd_req_ready = from_mem_rd_req_ready;
            end
        end
        if (in_resp) begin
            if (owner_q == OWN_D) begin
                to_mem_rd_rsp_ready = dc_rd_rsp_ready;
                dc_rd_rsp_valid     = from_mem_rd_rsp_valid;
                dc_rd_rsp_data      = from_mem_rd_rsp_data;
                dc_rd_rsp_last      = from_mem_rd_rsp_last;
            end else begin
                to_mem_rd_rsp_ready = ic_rd_rsp_ready;
                ic_rd_rsp_valid     = from_mem_rd_rsp_valid;
                ic_rd_rsp_data      = from_mem_rd_rsp_data;
                ic_rd_rsp_last      = from_mem_rd_rsp_last;
            end
        end
    end

    // Status outputs
    assign busy      = !in_idle;
    assign burst_err = burst_err_q;

endmodule

// File: tb/tb_cache_mem_rd_arbiter.sv
// Randomized bench for cache_mem_rd_arbiter with a grant/beat reference model.
// Expectations follow ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_cache_mem_rd_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [AW-1:0] MASK = 32'hFFFF_FFE0;

    logic          clk = 1'b0;
    logic          rst;
    logic          ic_rd_req_valid, ic_rd_req_ready, ic_rd_rsp_valid, ic_rd_rsp_last, ic_rd_rsp_ready;
    logic [AW-1:0] ic_rd_req_addr;
    logic [DW-1:0] ic_rd_rsp_data;
    logic          dc_rd_req_valid, dc_rd_req_ready, dc_rd_rsp_valid, dc_rd_rsp_last, dc_rd_rsp_ready;
    logic [AW-1:0] dc_rd_req_addr;
    logic [DW-1:0] dc_rd_rsp_data;
    logic          to_mem_rd_req_valid, from_mem_rd_req_ready;
    logic [AW-1:0] to_mem_rd_req_addr;
    logic          from_mem_rd_rsp_valid, from_mem_rd_rsp_last, to_mem_rd_rsp_ready;
    logic [DW-1:0] from_mem_rd_rsp_data;
    logic          busy, burst_err;

    always #5 clk = ~clk;

    cache_mem_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(8)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .ic_rd_req_valid       (ic_rd_req_valid),
        .ic_rd_req_addr        (ic_rd_req_addr),
        .ic_rd_req_ready       (ic_rd_req_ready),
        .ic_rd_rsp_valid       (ic_rd_rsp_valid),
        .ic_rd_rsp_data        (ic_rd_rsp_data),
        .ic_rd_rsp_last        (ic_rd_rsp_last),
        .ic_rd_rsp_ready       (ic_rd_rsp_ready),
        .dc_rd_req_valid       (dc_rd_req_valid),
        .dc_rd_req_addr        (dc_rd_req_addr),
        .dc_rd_req_ready       (dc_rd_req_ready),
        .dc_rd_rsp_valid       (dc_rd_rsp_valid),
        .dc_rd_rsp_data        (dc_rd_rsp_data),
        .dc_rd_rsp_last        (dc_rd_rsp_last),
        .dc_rd_rsp_ready       (dc_rd_rsp_ready),
        .to_mem_rd_req_valid   (to_mem_rd_req_valid),
        .to_mem_rd_req_addr    (to_mem_rd_req_addr),
        .from_mem_rd_req_ready (from_mem_rd_req_ready),
        .from_mem_rd_rsp_valid (from_mem_rd_rsp_valid),
        .from_mem_rd_rsp_data  (from_mem_rd_rsp_data),
        .from_mem_rd_rsp_last  (from_mem_rd_rsp_last),
        .to_mem_rd_rsp_ready   (to_mem_rd_rsp_ready),
        .busy                  (busy),
        .burst_err             (burst_err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Requester behaviour and model state
    bit ic_hold, dc_hold;
    bit model_last;

    // Observations of the most recent burst
    int            rec_own, rec_wait, rec_stray, rec_mirror, rec_lastcnt, rec_lastpos;
    bit            rec_tmo;
    logic [AW-1:0] rec_addr;
    logic [DW-1:0] rec_base;
    logic [DW-1:0] rec_q[$];

    // Arbitration rule: lone requester wins; ties by priority or alternation
    function automatic int model_grant(input bit i, input bit d);
        int w;
        if (i && d) w = RR ? (model_last ? 0 : 1) : 1;
        else if (d) w = 1;
        else        w = 0;
        model_last = w[0];
        return w;
    endfunction

    function automatic int seq_errors();
        int bad = 0;
        foreach (rec_q[k]) if (rec_q[k] !== rec_base + DW'(k)) bad++;
        return bad;
    endfunction

    task automatic clear_inputs();
        ic_rd_req_valid = 0; ic_rd_req_addr = '0; ic_rd_rsp_ready = 0;
        dc_rd_req_valid = 0; dc_rd_req_addr = '0; dc_rd_rsp_ready = 0;
        from_mem_rd_req_ready = 0; from_mem_rd_rsp_valid = 0;
        from_mem_rd_rsp_data = '0; from_mem_rd_rsp_last = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1; clear_inputs(); ic_hold = 0; dc_hold = 0; model_last = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    // Memory side of one burst plus cache-side beat collection.
    // Starts just after a negedge; returns just after a negedge.
    task automatic serve_burst(input int last_idx, input bit tog, input int rst_at,
                               input logic [DW-1:0] base);
        int   t;
        int   beat;
        logic rdy;
        rec_own = -1; rec_wait = 0; rec_stray = 0; rec_mirror = 0;
        rec_lastcnt = 0; rec_lastpos = -1; rec_tmo = 0; rec_addr = '0;
        rec_q.delete(); rec_base = base;
        #1;
        while (!to_mem_rd_req_valid && rec_wait < 20) begin
            @(negedge clk); #1; rec_wait++;
        end
        if (!to_mem_rd_req_valid) begin rec_tmo = 1; return; end
        rec_addr = to_mem_rd_req_addr;
        from_mem_rd_req_ready = 1;
        #1;
        if (ic_rd_req_ready === 1'b1 && dc_rd_req_ready === 1'b0) rec_own = 0;
        else if (dc_rd_req_ready === 1'b1 && ic_rd_req_ready === 1'b0) rec_own = 1;
        @(negedge clk);
        from_mem_rd_req_ready = 0;
        if (rec_own == 0 && !ic_hold) ic_rd_req_valid = 0;
        if (rec_own == 1 && !dc_hold) dc_rd_req_valid = 0;
        beat = 0; t = 0;
        while (beat <= last_idx && t < 100) begin
            rdy = tog ? ((t % 2) == 1) : 1'b1;
            ic_rd_rsp_ready = (rec_own == 1) ? ~rdy : rdy;
            dc_rd_rsp_ready = (rec_own == 1) ? rdy : ~rdy;
            from_mem_rd_rsp_valid = 1;
            from_mem_rd_rsp_data  = base + DW'(beat);
            from_mem_rd_rsp_last  = (beat == last_idx);
            if (beat == rst_at) begin
                rst = 1; #1;
                return;
            end
            #1;
            if (to_mem_rd_rsp_ready !== rdy) rec_mirror++;
            if (rec_own == 1) begin
                if (ic_rd_rsp_valid !== 1'b0 || ic_rd_rsp_data !== '0 || ic_rd_rsp_last !== 1'b0) rec_stray++;
                if (dc_rd_rsp_valid === 1'b1 && dc_rd_rsp_ready) begin
                    rec_q.push_back(dc_rd_rsp_data);
                    if (dc_rd_rsp_last === 1'b1) begin rec_lastcnt++; rec_lastpos = rec_q.size() - 1; end
                end
            end else begin
                if (dc_rd_rsp_valid !== 1'b0 || dc_rd_rsp_data !== '0 || dc_rd_rsp_last !== 1'b0) rec_stray++;
                if (ic_rd_rsp_valid === 1'b1 && ic_rd_rsp_ready) begin
                    rec_q.push_back(ic_rd_rsp_data);
                    if (ic_rd_rsp_last === 1'b1) begin rec_lastcnt++; rec_lastpos = rec_q.size() - 1; end
                end
            end
            if (to_mem_rd_rsp_ready === 1'b1) beat++;
            @(negedge clk);
            t++;
        end
        if (beat <= last_idx) rec_tmo = 1;
        from_mem_rd_rsp_valid = 0; from_mem_rd_rsp_data = '0; from_mem_rd_rsp_last = 0;
        ic_rd_rsp_ready = 0; dc_rd_rsp_ready = 0;
    endtask

    task automatic test_reset();
        logic [9:0] flags;
        apply_reset();
        from_mem_rd_rsp_valid = 1; from_mem_rd_rsp_last = 1;
        from_mem_rd_rsp_data = $urandom; from_mem_rd_req_ready = 1;
        ic_rd_rsp_ready = 1; dc_rd_rsp_ready = 1;
        #1;
        flags = {busy, burst_err, to_mem_rd_req_valid, to_mem_rd_rsp_ready, ic_rd_req_ready,
                 dc_rd_req_ready, ic_rd_rsp_valid, dc_rd_rsp_valid, ic_rd_rsp_last, dc_rd_rsp_last};
        n_vec++;
        if (flags !== '0) begin n_err++; $display("FAIL reset_flags: got %b expected 0", flags); end
        n_vec++;
        if (to_mem_rd_req_addr !== '0) begin n_err++; $display("FAIL reset_addr: got %h expected 0", to_mem_rd_req_addr); end
        n_vec++;
        if (ic_rd_rsp_data !== '0 || dc_rd_rsp_data !== '0) begin
            n_err++; $display("FAIL reset_data: got ic %h dc %h expected 0", ic_rd_rsp_data, dc_rd_rsp_data);
        end
        clear_inputs();
    endtask

    task automatic test_lone_i();
        apply_reset();
        ic_rd_req_addr = 32'h0000_1234; ic_rd_req_valid = 1;
        #1;
        n_vec++;
        if (to_mem_rd_req_valid !== 1'b0) begin n_err++; $display("FAIL lone_same_cycle: req_valid %b expected 0", to_mem_rd_req_valid); end
        serve_burst(7, 0, -1, '0);
        n_vec++;
        if (rec_tmo || rec_wait != 1) begin n_err++; $display("FAIL lone_latency: tmo %0d wait %0d expected 0/1", rec_tmo, rec_wait); end
        n_vec++;
        if (rec_own != 0) begin n_err++; $display("FAIL lone_owner: got %0d expected 0", rec_own); end
        n_vec++;
        if (rec_addr !== 32'h0000_1220) begin n_err++; $display("FAIL lone_addr: got %h expected 00001220", rec_addr); end
        n_vec++;
        if (rec_q.size() != 8 || seq_errors() != 0) begin
            n_err++; $display("FAIL lone_beats: got %0d beats %0d bad expected 8/0", rec_q.size(), seq_errors());
        end
        n_vec++;
        if (rec_lastcnt != 1 || rec_lastpos != 7) begin
            n_err++; $display("FAIL lone_last: count %0d pos %0d expected 1/7", rec_lastcnt, rec_lastpos);
        end
        n_vec++;
        if (rec_stray != 0) begin n_err++; $display("FAIL lone_dc_quiet: %0d stray cycles expected 0", rec_stray); end
        #1;
        n_vec++;
        if (busy !== 1'b0 || burst_err !== 1'b0) begin
            n_err++; $display("FAIL lone_idle_after: busy %b err %b expected 0/0", busy, burst_err);
        end
    endtask

    task automatic test_tie();
        logic [AW-1:0] ia, da;
        int            e;
        apply_reset();
        ia = $urandom; da = $urandom;
        ic_rd_req_addr = ia; dc_rd_req_addr = da;
        ic_rd_req_valid = 1; dc_rd_req_valid = 1;
        e = model_grant(1, 1);
        serve_burst(7, 0, -1, $urandom);
        n_vec++;
        if (rec_own != e || rec_addr !== (da & MASK)) begin
            n_err++; $display("FAIL tie_first: owner %0d addr %h expected %0d %h", rec_own, rec_addr, e, da & MASK);
        end
        e = model_grant(1, 0);
        serve_burst(7, 0, -1, $urandom);
        n_vec++;
        if (rec_own != e || rec_addr !== (ia & MASK) || rec_q.size() != 8) begin
            n_err++; $display("FAIL tie_second: owner %0d addr %h beats %0d expected %0d %h 8", rec_own, rec_addr, rec_q.size(), e, ia & MASK);
        end
        n_vec++;
        if (rec_wait != 1) begin n_err++; $display("FAIL tie_gap: wait %0d expected 1", rec_wait); end
    endtask

    task automatic test_hold();
        int e;
        apply_reset();
        ic_hold = 1; dc_hold = 1;
        ic_rd_req_addr = $urandom; dc_rd_req_addr = $urandom;
        ic_rd_req_valid = 1; dc_rd_req_valid = 1;
        for (int b = 0; b < 4; b++) begin
            e = model_grant(1, 1);
            serve_burst(7, 0, -1, $urandom);
            n_vec++;
            if (rec_own != e || rec_q.size() != 8 || rec_tmo) begin
                n_err++; $display("FAIL hold_burst%0d: owner %0d beats %0d expected %0d 8", b, rec_own, rec_q.size(), e);
            end
        end
        dc_hold = 0; dc_rd_req_valid = 0; ic_hold = 0;
        e = model_grant(1, 0);
        serve_burst(7, 0, -1, $urandom);
        n_vec++;
        if (rec_own != e || rec_addr !== (ic_rd_req_addr & MASK)) begin
            n_err++; $display("FAIL hold_release: owner %0d addr %h expected %0d %h", rec_own, rec_addr, e, ic_rd_req_addr & MASK);
        end
    endtask

    task automatic test_toggle();
        apply_reset();
        dc_rd_req_addr = $urandom; dc_rd_req_valid = 1;
        serve_burst(7, 1, -1, $urandom);
        n_vec++;
        if (rec_mirror != 0) begin n_err++; $display("FAIL toggle_mirror: %0d cycles differ expected 0", rec_mirror); end
        n_vec++;
        if (rec_own != 1 || rec_q.size() != 8 || seq_errors() != 0 || rec_stray != 0) begin
            n_err++; $display("FAIL toggle_beats: owner %0d beats %0d bad %0d stray %0d expected 1 8 0 0",
                              rec_own, rec_q.size(), seq_errors(), rec_stray);
        end
    endtask

    task automatic test_burst_err();
        apply_reset();
        ic_rd_req_addr = $urandom; ic_rd_req_valid = 1;
        serve_burst(5, 0, -1, $urandom);
        #1;
        n_vec++;
        if (burst_err !== 1'b1 || busy !== 1'b0 || rec_q.size() != 6) begin
            n_err++; $display("FAIL short_burst: err %b busy %b beats %0d expected 1 0 6", burst_err, busy, rec_q.size());
        end
        dc_rd_req_addr = $urandom; dc_rd_req_valid = 1;
        serve_burst(7, 0, -1, $urandom);
        #1;
        n_vec++;
        if (burst_err !== 1'b1 || rec_q.size() != 8) begin
            n_err++; $display("FAIL err_sticky: err %b beats %0d expected 1 8", burst_err, rec_q.size());
        end
        apply_reset();
        #1;
        n_vec++;
        if (burst_err !== 1'b0) begin n_err++; $display("FAIL err_clear: err %b expected 0", burst_err); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] flags;
        logic [AW-1:0] ia;
        apply_reset();
        dc_rd_req_addr = $urandom; dc_rd_req_valid = 1;
        serve_burst(7, 0, 3, $urandom);
        flags = {busy, burst_err, to_mem_rd_req_valid, to_mem_rd_rsp_ready, ic_rd_req_ready,
                 dc_rd_req_ready, ic_rd_rsp_valid, dc_rd_rsp_valid, ic_rd_rsp_last, dc_rd_rsp_last};
        n_vec++;
        if (flags !== '0 || dc_rd_rsp_data !== '0 || to_mem_rd_req_addr !== '0) begin
            n_err++; $display("FAIL mid_reset: flags %b data %h addr %h expected all 0", flags, dc_rd_rsp_data, to_mem_rd_req_addr);
        end
        clear_inputs();
        @(negedge clk);
        rst = 0; model_last = 0;
        ia = $urandom;
        ic_rd_req_addr = ia; ic_rd_req_valid = 1;
        serve_burst(7, 0, -1, $urandom);
        n_vec++;
        if (rec_tmo || rec_wait != 1 || rec_own != 0 || rec_addr !== (ia & MASK) ||
            rec_q.size() != 8 || seq_errors() != 0) begin
            n_err++; $display("FAIL after_reset: tmo %0d wait %0d owner %0d addr %h beats %0d expected 0 1 0 %h 8",
                              rec_tmo, rec_wait, rec_own, rec_addr, rec_q.size(), ia & MASK);
        end
    endtask

    task automatic test_random();
        int            e, li;
        bit            tog, exp_err;
        logic [AW-1:0] ea;
        apply_reset();
        exp_err = 0;
        for (int it = 0; it < 12; it++) begin
            if (!ic_rd_req_valid && $urandom_range(0, 1) == 1) begin ic_rd_req_valid = 1; ic_rd_req_addr = $urandom; end
            if (!dc_rd_req_valid && $urandom_range(0, 1) == 1) begin dc_rd_req_valid = 1; dc_rd_req_addr = $urandom; end
            if (!ic_rd_req_valid && !dc_rd_req_valid) begin
                if ($urandom_range(0, 1) == 1) begin ic_rd_req_valid = 1; ic_rd_req_addr = $urandom; end
                else begin dc_rd_req_valid = 1; dc_rd_req_addr = $urandom; end
            end
            e   = model_grant(ic_rd_req_valid, dc_rd_req_valid);
            ea  = ((e == 1) ? dc_rd_req_addr : ic_rd_req_addr) & MASK;
            li  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 7;
            tog = 1'($urandom_range(0, 1));
            if (li != 7) exp_err = 1;
            serve_burst(li, tog, -1, $urandom);
            #1;
            n_vec++;
            if (rec_tmo || rec_own != e || rec_addr !== ea) begin
                n_err++; $display("FAIL rand%0d_grant: tmo %0d owner %0d addr %h expected 0 %0d %h", it, rec_tmo, rec_own, rec_addr, e, ea);
            end
            n_vec++;
            if (rec_q.size() != li + 1 || seq_errors() != 0 || rec_lastcnt != 1 || rec_lastpos != li) begin
                n_err++; $display("FAIL rand%0d_beats: beats %0d bad %0d lastpos %0d expected %0d 0 %0d",
                                  it, rec_q.size(), seq_errors(), rec_lastpos, li + 1, li);
            end
            n_vec++;
            if (rec_stray != 0 || rec_mirror != 0 || burst_err !== exp_err || busy !== 1'b0) begin
                n_err++; $display("FAIL rand%0d_status: stray %0d mirror %0d err %b busy %b expected 0 0 %b 0",
                                  it, rec_stray, rec_mirror, burst_err, busy, exp_err);
            end
        end
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_lone_i();
        test_tie();
        test_hold();
        test_toggle();
        test_burst_err();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
